// File: rtl/matrix_pkg.sv
// Shared definitions for the element-wise matrix engine: size defaults,
// mode encodings, FSM state type and the flat-bus element index helper.
package matrix_pkg;

  localparam int DEF_MAX_DIM    = 5;
  localparam int DEF_ELEM_WIDTH = 8;

  localparam logic [1:0] MODE_ADD      = 2'b00;
  localparam logic [1:0] MODE_SUB      = 2'b01;
  localparam logic [1:0] MODE_SCALAR   = 2'b10;
  localparam logic [1:0] MODE_HADAMARD = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Bit offset of element (r,c) in a row-major flat matrix bus.
  function automatic int elem_idx(input int r, input int c,
                                  input int max_dim = DEF_MAX_DIM,
                                  input int elem_w  = DEF_ELEM_WIDTH);
    return (r * max_dim + c) * elem_w;
  endfunction

endpackage

// File: rtl/matrix_elem_alu.sv
// Single-element arithmetic for add/sub/scalar/Hadamard; clamps when MATRIX_ELEMWISE_SATURATE_EN.
// Latency: combinational, zero cycles.
// Backpressure: none; result follows inputs.
module matrix_elem_alu
  import matrix_pkg::*;
#(
  parameter int ELEM_WIDTH = DEF_ELEM_WIDTH
) (
  input  logic [1:0]            mode,
  input  logic [ELEM_WIDTH-1:0] a,
  input  logic [ELEM_WIDTH-1:0] b,
  input  logic [ELEM_WIDTH-1:0] scalar,
  output logic [ELEM_WIDTH-1:0] result
);

  logic [ELEM_WIDTH:0]     sum;
  logic [ELEM_WIDTH:0]     diff;
  logic [ELEM_WIDTH-1:0]   mul_b;
  logic [2*ELEM_WIDTH-1:0] prod;

  assign sum   = {1'b0, a} + {1'b0, b};
  assign diff  = {1'b0, a} - {1'b0, b};
  assign mul_b = (mode == MODE_SCALAR) ? scalar : b;
  assign prod  = {{ELEM_WIDTH{1'b0}}, a} * {{ELEM_WIDTH{1'b0}}, mul_b};

  always_comb begin
    result = '0;
    case (mode)
`ifdef MATRIX_ELEMWISE_SATURATE_EN
      // diff MSB is the borrow out of the subtraction, i.e. a < b.
      MODE_ADD: result = sum[ELEM_WIDTH] ? '1 : sum[ELEM_WIDTH-1:0];
      MODE_SUB: result = diff[ELEM_WIDTH] ? '0 : diff[ELEM_WIDTH-1:0];
      default:  result = (prod[2*ELEM_WIDTH-1:ELEM_WIDTH] != '0) ? '1
                                                                  : prod[ELEM_WIDTH-1:0];
`else
      MODE_ADD: result = sum[ELEM_WIDTH-1:0];
      MODE_SUB: result = diff[ELEM_WIDTH-1:0];
      default:  result = prod[ELEM_WIDTH-1:0];
`endif
    endcase
  end

endmodule

// File: rtl/matrix_elemwise_unit.sv
// Sequential element-wise matrix engine, one element per clock row-major (MATRIX_ELEMWISE_SATURATE_EN clamps).
// Latency: start edge to done pulse is m*n+2 cycles, or 2 cycles for illegal dimensions.
// Backpressure: none; start is only honoured in IDLE, never queued.
module matrix_elemwise_unit
  import matrix_pkg::*;
#(
  parameter  int MAX_DIM    = DEF_MAX_DIM,
  parameter  int ELEM_WIDTH = DEF_ELEM_WIDTH,
  localparam int DIM_W      = $clog2(MAX_DIM + 1),
  localparam int MAT_W      = MAX_DIM * MAX_DIM * ELEM_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [1:0]            mode,
  input  logic [DIM_W-1:0]      m,
  input  logic [DIM_W-1:0]      n,
  input  logic [ELEM_WIDTH-1:0] scalar_in,
  input  logic [MAT_W-1:0]      matrixA_in,
  input  logic [MAT_W-1:0]      matrixB_in,
  output logic [MAT_W-1:0]      matrix_out,
  output logic                  busy,
  output logic                  done,
  output logic                  valid,
  output logic                  error
);

  state_t                state, state_n;
  logic [1:0]            mode_q;
  logic [DIM_W-1:0]      m_q, n_q, r, c;
  logic [ELEM_WIDTH-1:0] scalar_q;
  logic [MAT_W-1:0]      a_q, b_q;
  logic [ELEM_WIDTH-1:0] a_el, b_el, res_el;
  logic                  dims_bad, last_col, last_el;
  int                    cur_idx;

  assign dims_bad = (m_q == '0) || (n_q == '0) ||
                    (m_q > DIM_W'(MAX_DIM)) || (n_q > DIM_W'(MAX_DIM));
  assign last_col = (c == n_q - DIM_W'(1));
  assign last_el  = last_col && (r == m_q - DIM_W'(1));
  assign busy     = (state == S_CHECK) || (state == S_RUN);

  assign cur_idx = elem_idx(int'(r), int'(c), MAX_DIM, ELEM_WIDTH);
  assign a_el    = a_q[cur_idx +: ELEM_WIDTH];
  assign b_el    = b_q[cur_idx +: ELEM_WIDTH];

  matrix_elem_alu #(.ELEM_WIDTH(ELEM_WIDTH)) u_alu (
    .mode   (mode_q),
    .a      (a_el),
    .b      (b_el),
    .scalar (scalar_q),
    .result (res_el)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (start) state_n = S_CHECK;
      S_CHECK: state_n = dims_bad ? S_DONE : S_RUN;
      S_RUN:   if (last_el) state_n = S_DONE;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q     <= MODE_ADD;
      m_q        <= '0;
      n_q        <= '0;
      scalar_q   <= '0;
      a_q        <= '0;
      b_q        <= '0;
      r          <= '0;
      c          <= '0;
      matrix_out <= '0;
      done       <= 1'b0;
      valid      <= 1'b0;
      error      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            mode_q     <= mode;
            m_q        <= m;
            n_q        <= n;
            scalar_q   <= scalar_in;
            a_q        <= matrixA_in;
            b_q        <= matrixB_in;
            matrix_out <= '0;
            valid      <= 1'b0;
            error      <= 1'b0;
          end
        end
        S_CHECK: begin
          r <= '0;
          c <= '0;
          if (dims_bad) begin
            error <= 1'b1;
            done  <= 1'b1;
          end
        end
        S_RUN: begin
          matrix_out[cur_idx +: ELEM_WIDTH] <= res_el;
          if (last_col) begin
            c <= '0;
            r <= r + DIM_W'(1);
          end else begin
            c <= c + DIM_W'(1);
          end
          // done/valid are registered so they rise together with the DONE state.
          if (last_el) begin
            done  <= 1'b1;
            valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
